// File: rtl/reg_read.sv
// Register-read stage: a physical register file with two writeback ports feeds
// a 2-entry in-order skid FIFO whose entries keep snooping writebacks until they issue.
module reg_read #(
  parameter int unsigned IQLSQ_WIDTH = 137,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PHYS_REGS   = 64
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [IQLSQ_WIDTH-1:0] ISS_popData_IN,
  input  logic                   ISS_valid_IN,
  input  logic                   ISS_mem_IN,
  input  logic                   WB0_we_IN,
  input  logic [5:0]             WB0_reg_IN,
  input  logic [DATA_WIDTH-1:0]  WB0_data_IN,
  input  logic                   WB1_we_IN,
  input  logic [5:0]             WB1_reg_IN,
  input  logic [DATA_WIDTH-1:0]  WB1_data_IN,
  input  logic                   EX_stall_IN,
  output logic                   FREEZE_OUT,
  output logic                   EX_valid_OUT,
  output logic                   EX_mem_OUT,
  output logic [DATA_WIDTH-1:0]  EX_src1_OUT,
  output logic [DATA_WIDTH-1:0]  EX_src2_OUT,
  output logic [5:0]             EX_dest_OUT,
  output logic                   EX_needDest_OUT,
  output logic [5:0]             EX_aluCtl_OUT,
  output logic [5:0]             EX_rob_OUT,
  output logic [31:0]            EX_pc_OUT,
  output logic [31:0]            EX_instr_OUT,
  output logic                   OVF_OUT
);

  localparam int unsigned RW = $clog2(PHYS_REGS);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [5:0]            s1;
    logic [5:0]            s2;
    logic                  imm_src;
    logic                  mem;
    logic [5:0]            dest;
    logic                  need_dest;
    logic [5:0]            alu;
    logic [5:0]            rob;
    logic [31:0]           pc;
    logic [31:0]           instr;
  } entry_t;

  logic [DATA_WIDTH-1:0] rf_q [PHYS_REGS];
  entry_t                mem_q [2];
  entry_t                mem_d [2];
  logic [1:0]            cnt_q, cnt_d;
  logic                  wp_q, wp_d;
  logic                  rp_q, rp_d;
  logic                  ovf_q, ovf_d;

  logic                  pop, push_ok;
  entry_t                new_e, head;

  logic [5:0]            iss_s1, iss_s2;
  logic                  iss_imm_src;
  logic [31:0]           iss_imm;
  logic                  unused_iss_bits;

  assign iss_s1      = ISS_popData_IN[81:76];
  assign iss_s2      = ISS_popData_IN[88:83];
  assign iss_imm_src = ISS_popData_IN[97];
  assign iss_imm     = ISS_popData_IN[75:44];
  assign unused_iss_bits = ^{ISS_popData_IN[104:98], ISS_popData_IN[89], ISS_popData_IN[82]};

  // WB1 has priority over WB0, which has priority over the supplied value.
  function automatic logic [DATA_WIDTH-1:0] pick(
    input logic [DATA_WIDTH-1:0] base,
    input logic [5:0]            r,
    input logic                  w0,
    input logic [5:0]            r0,
    input logic [DATA_WIDTH-1:0] d0,
    input logic                  w1,
    input logic [5:0]            r1,
    input logic [DATA_WIDTH-1:0] d1
  );
    logic [DATA_WIDTH-1:0] v;
    v = base;
    if (w0 && (r0 == r)) v = d0;
    if (w1 && (r1 == r)) v = d1;
    return v;
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < PHYS_REGS; i++) rf_q[i] <= '0;
    end else begin
      if (WB0_we_IN) rf_q[RW'(WB0_reg_IN)] <= WB0_data_IN;
      if (WB1_we_IN) rf_q[RW'(WB1_reg_IN)] <= WB1_data_IN;
    end
  end

  always_comb begin
    new_e           = '0;
    new_e.s1        = iss_s1;
    new_e.s2        = iss_s2;
    new_e.imm_src   = iss_imm_src;
    new_e.mem       = ISS_mem_IN;
    new_e.dest      = ISS_popData_IN[95:90];
    new_e.need_dest = ISS_popData_IN[96];
    new_e.alu       = ISS_popData_IN[43:38];
    new_e.rob       = ISS_popData_IN[37:32];
    new_e.pc        = ISS_popData_IN[136:105];
    new_e.instr     = ISS_popData_IN[31:0];
    new_e.op1       = pick(rf_q[RW'(iss_s1)], iss_s1, WB0_we_IN, WB0_reg_IN, WB0_data_IN,
                           WB1_we_IN, WB1_reg_IN, WB1_data_IN);
    if (iss_imm_src)
      new_e.op2 = DATA_WIDTH'(iss_imm);
    else
      new_e.op2 = pick(rf_q[RW'(iss_s2)], iss_s2, WB0_we_IN, WB0_reg_IN, WB0_data_IN,
                       WB1_we_IN, WB1_reg_IN, WB1_data_IN);
  end

  // A push at full occupancy is still accepted when the head pops in the same cycle.
  always_comb begin
    pop     = (cnt_q != 2'd0) && !EX_stall_IN;
    push_ok = ISS_valid_IN && ((cnt_q != 2'd2) || pop);
    ovf_d   = ovf_q | (ISS_valid_IN && (cnt_q == 2'd2) && !pop);
    cnt_d   = cnt_q + {1'b0, push_ok} - {1'b0, pop};
    wp_d    = wp_q + push_ok;
    rp_d    = rp_q + pop;
    mem_d   = mem_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if ((cnt_q == 2'd2) || ((cnt_q == 2'd1) && (rp_q == 1'(i)))) begin
        mem_d[i].op1 = pick(mem_q[i].op1, mem_q[i].s1, WB0_we_IN, WB0_reg_IN, WB0_data_IN,
                            WB1_we_IN, WB1_reg_IN, WB1_data_IN);
        if (!mem_q[i].imm_src)
          mem_d[i].op2 = pick(mem_q[i].op2, mem_q[i].s2, WB0_we_IN, WB0_reg_IN, WB0_data_IN,
                              WB1_we_IN, WB1_reg_IN, WB1_data_IN);
      end
    end
    if (push_ok) mem_d[wp_q] = new_e;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      ovf_q <= '0;
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      ovf_q <= ovf_d;
      mem_q <= mem_d;
    end
  end

  assign head            = mem_q[rp_q];
  assign EX_valid_OUT    = (cnt_q != 2'd0);
  assign EX_mem_OUT      = head.mem;
  assign EX_src1_OUT     = head.op1;
  assign EX_src2_OUT     = head.op2;
  assign EX_dest_OUT     = head.dest;
  assign EX_needDest_OUT = head.need_dest;
  assign EX_aluCtl_OUT   = head.alu;
  assign EX_rob_OUT      = head.rob;
  assign EX_pc_OUT       = head.pc;
  assign EX_instr_OUT    = head.instr;
  assign OVF_OUT         = ovf_q;
  assign FREEZE_OUT      = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && EX_stall_IN);

endmodule

// File: doc/reg_read.md
REG_READ -- requirements
Module: reg_read

Interface
REQ-001 SHALL have parameter IQLSQ_WIDTH, default 137, the width of an issued IQ/LSQ entry.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the register value width.
REQ-003 SHALL have parameter PHYS_REGS, default 64, the physical register count (6-bit specifiers).
REQ-004 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 ISS_popData_IN  input  IQLSQ_WIDTH  issued entry; fields: PCA[136:105], immSrc[97], needDest[96], dest[95:90], src2[88:83], src1[81:76], imm[75:44], aluCtl[43:38], rob[37:32], instr[31:0].
REQ-007 ISS_valid_IN  input  1  entry valid this cycle.
REQ-008 ISS_mem_IN  input  1  entry is a load/store.
REQ-009 WB0_we_IN / WB0_reg_IN / WB0_data_IN  input  1/6/DATA_WIDTH  ALU writeback port.
REQ-010 WB1_we_IN / WB1_reg_IN / WB1_data_IN  input  1/6/DATA_WIDTH  load writeback port.
REQ-011 EX_stall_IN  input  1  execute stage cannot accept this cycle.
REQ-012 FREEZE_OUT  output  1  back-pressure to the issue stage.
REQ-013 EX_valid_OUT, EX_mem_OUT  output  1 each  head entry valid / is memory op.
REQ-014 EX_src1_OUT, EX_src2_OUT  output  DATA_WIDTH each  operand values (src2 = imm when immSrc=1).
REQ-015 EX_dest_OUT, EX_needDest_OUT, EX_aluCtl_OUT, EX_rob_OUT  output  6/1/6/6  pass-through fields.
REQ-016 EX_pc_OUT, EX_instr_OUT  output  32 each  pass-through fields.
REQ-017 OVF_OUT  output  1  sticky overflow error flag.

Function
REQ-018 SHALL hold a PHYS_REGS x DATA_WIDTH register file written on each rising edge from WB0 and WB1 when their we is high.
REQ-019 When WB0 and WB1 target the same register in one cycle, WB1 SHALL win.
REQ-020 SHALL hold a 2-entry in-order skid FIFO (count 0..2); each entry stores operands plus pass-through fields.
REQ-021 On capture (ISS_valid_IN=1), operands SHALL be read from the register file with same-cycle WB bypass (WB1 over WB0 over file).
REQ-022 When immSrc=1, src2 operand SHALL be imm[75:44] and SHALL NOT be updated by snooping.
REQ-023 Every cycle, each occupied entry SHALL replace a register operand whose specifier matches an active WB port with that port's data (WB1 priority).
REQ-024 Head entry SHALL drive EX_* outputs from registered state only; EX_valid_OUT = (count != 0).
REQ-025 Pop SHALL occur when count != 0 and EX_stall_IN=0.
REQ-026 Latency SHALL be one cycle: entry captured at edge N is on EX_* after edge N when FIFO was empty.
REQ-027 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-028 FREEZE_OUT SHALL be combinational: (count==2) || (count==1 && EX_stall_IN).
REQ-029 A push arriving at count==2 without a pop SHALL be dropped and SHALL set OVF_OUT until reset.
REQ-030 Register-file read pointers and FIFO pointers SHALL wrap modulo their sizes.

Reset
REQ-031 RESET high SHALL asynchronously clear count, FIFO pointers, OVF_OUT and all register-file entries to 0.
REQ-032 During reset, EX_valid_OUT and FREEZE_OUT SHALL be 0; all other EX_* outputs SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries; no entry SHALL appear on EX_* after release until a new push.

Verification
REQ-034 Write WB0 reg 5 = 0x1234; next cycle push src1=5, src2=6 (reg6=0) -> one cycle later EX_valid_OUT=1, EX_src1_OUT=0x1234, EX_src2_OUT=0.
REQ-035 Push src1=7 in same cycle as WB0 reg7=0xA, WB1 reg7=0xB -> EX_src1_OUT=0xB.
REQ-036 Hold EX_stall_IN=1, push two entries -> FREEZE_OUT=1 after second push; third push -> OVF_OUT=1, entries 1,2 emerge in order after stall drops.
REQ-037 Push entry src2=9 with EX_stall_IN=1, then WB1 reg9=0x55 -> EX_src2_OUT becomes 0x55 next cycle; with immSrc=1, imm=0xFFFF0001 unchanged by WB.
REQ-038 Assert RESET with count=2 -> EX_valid_OUT=0, FREEZE_OUT=0, OVF_OUT=0 immediately; register file reads 0.
REQ-039 Continuous push every cycle, EX_stall_IN=0 -> count never exceeds 1, FREEZE_OUT stays 0, order preserved.
